mem_access_stage: RTL and testbench

Handshaked memory stage of the 5-stage pipeline, sitting between Execute and Writeback and replacing the single-cycle memory path. It takes the Execute-stage M-bundle, performs LDR/LDRB/STR/STRB through a req/ack data-memory port with byte lanes, a bus timeout and a stall back to upstream stages, and registers the W-bundle consumed by Writeback.

---
 rtl/mem_access_stage_if.sv | 21 ++
 rtl/mem_access_stage.sv | 125 ++++++++++++
 tb/tb_mem_access_stage.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage and data memory.
// The stage is the master; the memory (or bench responder) is the slave.
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_access_stage.sv
// Handshaked MEM stage: issues LDR/LDRB/STR/STRB over a req/ack bus with byte lanes,
// stalls upstream while the access is outstanding, and registers the W-bundle.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic        ByteM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALU_ResultM,
  mem_access_stage_if.master dmem,
  output logic        StallM,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic        BusErrW,
  output logic        AlignErrW
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state;
  logic [31:0] wait_cnt;
  logic        byte_q;
  logic [1:0]  lane_q;

  logic        memop;
  logic        timeout;
  logic        done;
  logic [31:0] rd_value;

  assign memop   = MemWriteM | ResultSrcM;
  // Fires in the TIMEOUT-th ACCESS cycle; an ack in that same cycle still wins.
  assign timeout = (TIMEOUT != 0) && (state == ACCESS) && (wait_cnt == 32'(TIMEOUT - 1));
  assign done    = (state == ACCESS) && (dmem.dmem_ack || timeout);

  always_comb begin
    StallM = 1'b0;
    if (state == IDLE) StallM = memop;
    else               StallM = ~dmem.dmem_ack & ~timeout;
  end

  always_comb begin
    rd_value = dmem.dmem_rdata;
    if (byte_q) rd_value = {24'b0, dmem.dmem_rdata[{lane_q, 3'b000} +: 8]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      byte_q          <= 1'b0;
      lane_q          <= 2'b00;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      dmem.dmem_be    <= '0;
      RegWriteW       <= 1'b0;
      ResultSrcW      <= 1'b0;
      RD_W            <= '0;
      PCPlus4W        <= '0;
      ALU_ResultW     <= '0;
      ReadDataW       <= '0;
      BusErrW         <= 1'b0;
      AlignErrW       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Non-memops flow straight to W; a memop leaves a bubble behind it.
          RegWriteW   <= memop ? 1'b0 : RegWriteM;
          ResultSrcW  <= 1'b0;
          RD_W        <= RD_M;
          PCPlus4W    <= PCPlus4M;
          ALU_ResultW <= ALU_ResultM;
          BusErrW     <= 1'b0;
          AlignErrW   <= 1'b0;
          if (memop) begin
            state           <= ACCESS;
            wait_cnt        <= '0;
            byte_q          <= ByteM;
            lane_q          <= ALU_ResultM[1:0];
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= MemWriteM;
            dmem.dmem_addr  <= {ALU_ResultM[31:2], 2'b00};
            dmem.dmem_wdata <= ByteM ? {4{WriteDataM[7:0]}} : WriteDataM;
            dmem.dmem_be    <= ByteM ? (4'b0001 << ALU_ResultM[1:0]) : 4'b1111;
          end
        end
        ACCESS: begin
          if (done) begin
            state         <= IDLE;
            dmem.dmem_req <= 1'b0;
            dmem.dmem_we  <= 1'b0;
            dmem.dmem_be  <= 4'b0000;
            RegWriteW     <= RegWriteM;
            ResultSrcW    <= ResultSrcM;
            RD_W          <= RD_M;
            PCPlus4W      <= PCPlus4M;
            ALU_ResultW   <= ALU_ResultM;
            ReadDataW     <= dmem.dmem_ack ? rd_value : 32'hDEADBEEF;
            BusErrW       <= ~dmem.dmem_ack;
            AlignErrW     <= ~byte_q & (lane_q != 2'b00);
          end else begin
            wait_cnt   <= wait_cnt + 32'd1;
            RegWriteW  <= 1'b0;
            ResultSrcW <= 1'b0;
            BusErrW    <= 1'b0;
            AlignErrW  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus a randomized
// run against a byte-addressed memory model and expectations derived from the access rules.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RegWriteM, MemWriteM, ResultSrcM, ByteM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
  logic        StallM, RegWriteW, ResultSrcW, BusErrW, AlignErrW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

  int checks = 0;
  int errors = 0;

  mem_access_stage_if bus();

  mem_access_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .ByteM(ByteM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
    .dmem(bus), .StallM(StallM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
    .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW),
    .BusErrW(BusErrW), .AlignErrW(AlignErrW)
  );

  always #5 clk = ~clk;

  // W-stage log for the back-to-back scenario: 0 marks a bubble.
  logic log_en = 1'b0;
  int   wlog[$];
  always @(posedge clk) begin
    #2;
    if (log_en) wlog.push_back((RegWriteW || ResultSrcW) ? {RegWriteW, ResultSrcW, RD_W} : 0);
  end

  task automatic set_m(input logic mw, input logic rs, input logic bt, input logic rw,
                       input logic [4:0] rd, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] pc);
    MemWriteM = mw; ResultSrcM = rs; ByteM = bt; RegWriteM = rw;
    RD_M = rd; ALU_ResultM = a; WriteDataM = wd; PCPlus4M = pc;
  endtask

  task automatic nop_m();
    set_m(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  // Drives one memop from IDLE (call at posedge+1) and acts as the memory responder.
  // waits < 0 never acks. Returns at posedge+1 after the W-bundle has been loaded.
  task automatic run_mem(input logic mw, input logic bt, input logic rw, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc,
                         input int waits, input logic [31:0] rdata,
                         output int stall_n, output int access_n,
                         output logic [31:0] c_addr, output logic [31:0] c_wdata,
                         output logic [3:0] c_be, output logic c_we,
                         output logic stable, output logic bubble_ok, output logic hung);
    set_m(mw, ~mw, bt, rw, rd, a, wd, pc);
    #1;
    stall_n = StallM ? 1 : 0;
    access_n = 0; stable = 1'b1; bubble_ok = 1'b1; hung = 1'b1;
    c_addr = 'x; c_wdata = 'x; c_be = 'x; c_we = 1'bx;
    for (int k = 0; k < 64; k++) begin
      @(posedge clk); #1;
      access_n++;
      if (k == 0) begin
        c_addr = bus.dmem_addr; c_wdata = bus.dmem_wdata; c_be = bus.dmem_be; c_we = bus.dmem_we;
      end
      if (bus.dmem_req !== 1'b1 || bus.dmem_addr !== c_addr || bus.dmem_wdata !== c_wdata ||
          bus.dmem_be !== c_be || bus.dmem_we !== c_we) stable = 1'b0;
      if (RegWriteW !== 1'b0 || ResultSrcW !== 1'b0 || BusErrW !== 1'b0 || AlignErrW !== 1'b0)
        bubble_ok = 1'b0;
      if (k == waits) begin bus.dmem_ack = 1'b1; bus.dmem_rdata = rdata; end
      #1;
      if (StallM) stall_n++;
      else begin
        @(posedge clk); #1;
        hung = 1'b0;
        break;
      end
    end
    bus.dmem_ack = 1'b0;
    nop_m();
  endtask

  int s_n, a_n;
  logic [31:0] c_addr, c_wdata;
  logic [3:0]  c_be;
  logic c_we, stable, bub, hung;

  task automatic test_reset();
    nop_m(); bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", bus.dmem_req); end
    checks++; if ({RegWriteW, ResultSrcW, BusErrW, AlignErrW} !== 4'b0) begin errors++; $display("FAIL reset_wctl got %b want 0000", {RegWriteW, ResultSrcW, BusErrW, AlignErrW}); end
    checks++; if (ReadDataW !== 32'h0 || ALU_ResultW !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h/%h want 0/0", ReadDataW, ALU_ResultW); end
    // Release with an ALU instruction already present in M.
    set_m(1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h2A, 32'h0, 32'h44);
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL alu_stall got %b want 0", StallM); end
    @(posedge clk); #1;
    checks++; if (RegWriteW !== 1'b1 || RD_W !== 5'd3 || ALU_ResultW !== 32'h2A || PCPlus4W !== 32'h44)
      begin errors++; $display("FAIL alu_w got rw=%b rd=%0d alu=%h pc=%h want 1 3 2a 44", RegWriteW, RD_W, ALU_ResultW, PCPlus4W); end
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL alu_stall2 got %b want 0", StallM); end
    $display("txn ALU rd=3 alu=0000002a");
    nop_m();
  endtask

  task automatic test_ldr_zero_wait();
    run_mem(1'b0, 1'b0, 1'b1, 5'd5, 32'h100, 32'hCAFE0000, 32'h1234, 0, 32'h12345678,
            s_n, a_n, c_addr, c_wdata, c_be, c_we, stable, bub, hung);
    checks++; if (s_n !== 1 || a_n !== 1) begin errors++; $display("FAIL ldr_timing got stall=%0d access=%0d want 1 1", s_n, a_n); end
    checks++; if (c_be !== 4'hF || c_addr !== 32'h100 || c_we !== 1'b0) begin errors++; $display("FAIL ldr_bus got be=%b addr=%h we=%b want 1111 100 0", c_be, c_addr, c_we); end
    checks++; if (ReadDataW !== 32'h12345678 || ResultSrcW !== 1'b1 || RegWriteW !== 1'b1 || RD_W !== 5'd5 || PCPlus4W !== 32'h1234)
      begin errors++; $display("FAIL ldr_w got rd=%h src=%b rw=%b dst=%0d pc=%h", ReadDataW, ResultSrcW, RegWriteW, RD_W, PCPlus4W); end
    checks++; if (!bub || hung) begin errors++; $display("FAIL ldr_bubble got bubble=%b hung=%b want 1 0", bub, hung); end
    $display("txn LDR addr=00000100 rdata=%h", ReadDataW);
  endtask

  task automatic test_strb_ldrb();
    run_mem(1'b1, 1'b1, 1'b0, 5'd0, 32'h203, 32'hAABBCCDD, 32'h0, 3, 32'h0,
            s_n, a_n, c_addr, c_wdata, c_be, c_we, stable, bub, hung);
    checks++; if (c_addr !== 32'h200 || c_be !== 4'b1000 || c_wdata !== 32'hDDDDDDDD || c_we !== 1'b1)
      begin errors++; $display("FAIL strb_bus got addr=%h be=%b wd=%h we=%b want 200 1000 dddddddd 1", c_addr, c_be, c_wdata, c_we); end
    checks++; if (!stable || a_n !== 4 || s_n !== 4) begin errors++; $display("FAIL strb_hold got stable=%b access=%0d stall=%0d want 1 4 4", stable, a_n, s_n); end
    checks++; if (RegWriteW !== 1'b0 || ResultSrcW !== 1'b0) begin errors++; $display("FAIL strb_nowrite got rw=%b src=%b want 0 0", RegWriteW, ResultSrcW); end
    $display("txn STRB addr=00000203 be=%b wdata=%h", c_be, c_wdata);
    run_mem(1'b0, 1'b1, 1'b1, 5'd9, 32'h201, 32'h0, 32'h0, 0, 32'h11223344,
            s_n, a_n, c_addr, c_wdata, c_be, c_we, stable, bub, hung);
    checks++; if (c_be !== 4'b0010 || c_addr !== 32'h200) begin errors++; $display("FAIL ldrb_bus got be=%b addr=%h want 0010 200", c_be, c_addr); end
    checks++; if (ReadDataW !== 32'h00000033 || AlignErrW !== 1'b0) begin errors++; $display("FAIL ldrb_data got %h align=%b want 00000033 0", ReadDataW, AlignErrW); end
    $display("txn LDRB addr=00000201 rdata=%h", ReadDataW);
  endtask

  task automatic test_timeout_align();
    run_mem(1'b0, 1'b0, 1'b1, 5'd4, 32'h300, 32'h0, 32'h0, -1, 32'h0,
            s_n, a_n, c_addr, c_wdata, c_be, c_we, stable, bub, hung);
    checks++; if (hung || a_n !== 16 || s_n !== 16) begin errors++; $display("FAIL timeout_len got hung=%b access=%0d stall=%0d want 0 16 16", hung, a_n, s_n); end
    checks++; if (ReadDataW !== 32'hDEADBEEF || BusErrW !== 1'b1 || RegWriteW !== 1'b1)
      begin errors++; $display("FAIL timeout_w got rd=%h buserr=%b rw=%b want deadbeef 1 1", ReadDataW, BusErrW, RegWriteW); end
    $display("txn LDR timeout rdata=%h buserr=%b", ReadDataW, BusErrW);
    run_mem(1'b0, 1'b0, 1'b1, 5'd6, 32'h102, 32'h0, 32'h0, 1, 32'h55AA55AA,
            s_n, a_n, c_addr, c_wdata, c_be, c_we, stable, bub, hung);
    checks++; if (AlignErrW !== 1'b1 || c_addr !== 32'h100 || BusErrW !== 1'b0 || ReadDataW !== 32'h55AA55AA)
      begin errors++; $display("FAIL align got align=%b addr=%h buserr=%b rd=%h want 1 100 0 55aa55aa", AlignErrW, c_addr, BusErrW, ReadDataW); end
    $display("txn LDR misaligned addr=00000102 alignerr=%b", AlignErrW);
  endtask

  task automatic test_reset_mid_access();
    set_m(1'b0, 1'b1, 1'b0, 1'b1, 5'd2, 32'h180, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; #1;
    checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL rst_mid_req got %b want 0", bus.dmem_req); end
    checks++; if ({RegWriteW, ResultSrcW, BusErrW, AlignErrW} !== 4'b0 || RD_W !== 5'd0 || ReadDataW !== 32'h0 || ALU_ResultW !== 32'h0 || PCPlus4W !== 32'h0)
      begin errors++; $display("FAIL rst_mid_w got ctl=%b rd=%0d data=%h", {RegWriteW, ResultSrcW, BusErrW, AlignErrW}, RD_W, ReadDataW); end
    checks++; if (StallM !== 1'b1) begin errors++; $display("FAIL rst_mid_stall_memop got %b want 1", StallM); end
    nop_m(); #1;
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL rst_mid_stall_nop got %b want 0", StallM); end
    @(negedge clk); rst = 1'b1;
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.dmem_req !== 1'b0 || StallM !== 1'b0 || RegWriteW !== 1'b0)
        begin errors++; $display("FAIL stray_ack got req=%b stall=%b rw=%b want 0 0 0", bus.dmem_req, StallM, RegWriteW); end
    end
    bus.dmem_ack = 1'b0;
    run_mem(1'b0, 1'b0, 1'b1, 5'd1, 32'h10, 32'h0, 32'h0, 0, 32'hA5A5A5A5,
            s_n, a_n, c_addr, c_wdata, c_be, c_we, stable, bub, hung);
    checks++; if (s_n !== 1 || a_n !== 1 || ReadDataW !== 32'hA5A5A5A5) begin errors++; $display("FAIL post_rst_ldr got stall=%0d access=%0d rd=%h", s_n, a_n, ReadDataW); end
    $display("txn reset mid-access, then LDR rdata=%h", ReadDataW);
  endtask

  task automatic test_back_to_back();
    int exp_log[5];
    exp_log = '{0, 7'b11_00111, 0, 7'b11_01000, 7'b10_01001};
    wlog.delete();
    #2; log_en = 1'b1;
    run_mem(1'b0, 1'b0, 1'b1, 5'd7, 32'h20, 32'h0, 32'h0, 0, 32'h1, s_n, a_n, c_addr, c_wdata, c_be, c_we, stable, bub, hung);
    run_mem(1'b0, 1'b0, 1'b1, 5'd8, 32'h24, 32'h0, 32'h0, 0, 32'h2, s_n, a_n, c_addr, c_wdata, c_be, c_we, stable, bub, hung);
    set_m(1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h77, 32'h0, 32'h0);
    @(posedge clk); #3; log_en = 1'b0;
    nop_m();
    checks++; if (wlog.size() !== 5) begin errors++; $display("FAIL b2b_len got %0d want 5", wlog.size()); end
    for (int i = 0; i < 5 && i < wlog.size(); i++) begin
      checks++; if (wlog[i] !== exp_log[i]) begin errors++; $display("FAIL b2b_w%0d got %h want %h", i, wlog[i], exp_log[i]); end
    end
    $display("txn back-to-back LDR LDR ADD, %0d W entries", wlog.size());
  endtask

  task automatic test_random();
    logic [31:0] mem [0:15];
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    @(negedge clk);
    @(posedge clk); #1;
    for (int n = 0; n < 40; n++) begin
      int kind, waits, idx, k;
      logic [31:0] a, wd, pc, word, exp_rd, exp_wd;
      logic [3:0] exp_be;
      logic [4:0] rd;
      logic rw, bt, st;
      kind = $urandom_range(0, 4);
      waits = $urandom_range(0, 3);
      a = 32'h400 + 32'($urandom_range(0, 63));
      wd = $urandom; pc = $urandom; rd = 5'($urandom_range(1, 31));
      idx = int'(a[5:2]); k = int'(a[1:0]);
      bt = (kind == 2 || kind == 4);
      st = (kind == 3 || kind == 4);
      rw = !st;
      if (kind == 0) begin
        set_m(1'b0, 1'b0, 1'b0, 1'b1, rd, a, wd, pc); #1;
        checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL rnd%0d_alu_stall got %b want 0", n, StallM); end
        @(posedge clk); #1;
        checks++; if (RegWriteW !== 1'b1 || ResultSrcW !== 1'b0 || RD_W !== rd || ALU_ResultW !== a || PCPlus4W !== pc)
          begin errors++; $display("FAIL rnd%0d_alu got rw=%b src=%b rd=%0d alu=%h", n, RegWriteW, ResultSrcW, RD_W, ALU_ResultW); end
        $display("txn %0d ALU rd=%0d alu=%h", n, rd, a);
        nop_m();
        continue;
      end
      word = mem[idx];
      exp_be = bt ? 4'(1 << k) : 4'hF;
      exp_wd = bt ? (wd & 32'hFF) * 32'h01010101 : wd;
      exp_rd = bt ? (word >> (8 * k)) & 32'hFF : word;
      run_mem(st, bt, rw, rd, a, wd, pc, waits, word, s_n, a_n, c_addr, c_wdata, c_be, c_we, stable, bub, hung);
      if (st) for (int b = 0; b < 4; b++) if (exp_be[b]) mem[idx][8*b +: 8] = exp_wd[8*b +: 8];
      checks++; if (c_addr !== (a & ~32'h3) || c_be !== exp_be || c_we !== st || !stable)
        begin errors++; $display("FAIL rnd%0d_bus got addr=%h be=%b we=%b stable=%b want %h %b %b 1", n, c_addr, c_be, c_we, stable, a & ~32'h3, exp_be, st); end
      checks++; if (st && c_wdata !== exp_wd) begin errors++; $display("FAIL rnd%0d_wdata got %h want %h", n, c_wdata, exp_wd); end
      checks++; if (s_n !== waits + 1 || a_n !== waits + 1) begin errors++; $display("FAIL rnd%0d_timing got stall=%0d access=%0d want %0d", n, s_n, a_n, waits + 1); end
      checks++; if (RegWriteW !== rw || ResultSrcW !== !st || RD_W !== rd || BusErrW !== 1'b0 || AlignErrW !== (!bt && k != 0))
        begin errors++; $display("FAIL rnd%0d_wctl got rw=%b src=%b rd=%0d be=%b al=%b", n, RegWriteW, ResultSrcW, RD_W, BusErrW, AlignErrW); end
      checks++; if (!st && ReadDataW !== exp_rd) begin errors++; $display("FAIL rnd%0d_rdata got %h want %h", n, ReadDataW, exp_rd); end
      $display("txn %0d %s%s addr=%h waits=%0d", n, st ? "ST" : "LD", bt ? "B" : "R", a, waits);
    end
  endtask

  initial begin
    test_reset();
    test_ldr_zero_wait();
    test_strb_ldrb();
    test_timeout_align();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
